// File: rtl/router_pkg.sv
// Shared router types and helpers for the input-port blocks.
package router_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ROUTER_NUM_VC = 2;
    localparam int ROUTER_DATA_W = 32;
    localparam int ROUTER_VC_W   = clog2_min1(ROUTER_NUM_VC);

    typedef logic [ROUTER_VC_W-1:0]   vc_id_t;
    typedef logic [ROUTER_DATA_W-1:0] flit_data_t;

    typedef struct packed {
        logic   valid;
        vc_id_t vc;
    } credit_t;

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual channel's circular FIFO: storage, head/tail pointers and occupancy.
// push/pop arrive already qualified by the parent, so no guarding is done here.
module vc_fifo_slice #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Explicit wrap so DEPTH need not be a power of two.
    always_comb begin
        head_d = head_q;
        if (push) begin
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
        end
        tail_d = tail_q;
        if (pop) begin
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        end
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[head_q] <= din;
        end
    end

    assign dout  = mem_q[tail_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/vc_input_buffer.sv
// Multi-VC input buffer for one router port: per-VC FIFOs behind a shared
// write port and a shared read port, with credit return and sticky error flags.
module vc_input_buffer
    import router_pkg::*;
#(
    parameter  int NUM_VC     = 2,
    parameter  int DEPTH      = 4,
    parameter  int DATA_W     = 32,
    parameter  int ROUTER_POS = 0,
    localparam int VC_W       = clog2_min1(NUM_VC),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [NUM_VC*CNT_W-1:0] vc_count,
    output logic [NUM_VC-1:0]       vc_empty,
    output logic [NUM_VC-1:0]       vc_full,
    output logic                    credit_valid,
    output logic [VC_W-1:0]         credit_vc,
    output logic                    err_overflow,
    output logic                    err_underflow
);

    logic [NUM_VC-1:0] wr_hit, rd_hit;
    logic [NUM_VC-1:0] push_ok, pop_ok;
    logic [NUM_VC-1:0] slice_empty, slice_full;
    logic [DATA_W-1:0] slice_dout  [NUM_VC];
    logic [CNT_W-1:0]  slice_count [NUM_VC];

    logic              overflow_evt, underflow_evt;
    logic              err_overflow_q, err_overflow_d;
    logic              err_underflow_q, err_underflow_d;
    logic              credit_valid_q, credit_valid_d;
    logic [VC_W-1:0]   credit_vc_q, credit_vc_d;

    // An out-of-range id matches no slice, so it falls through to the error path.
    // A full VC still accepts a write when the same VC is popped in that cycle.
    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        assign wr_hit[g]  = wr_en && (wr_vc == VC_W'(g));
        assign rd_hit[g]  = rd_en && (rd_vc == VC_W'(g));
        assign pop_ok[g]  = rd_hit[g] && !slice_empty[g];
        assign push_ok[g] = wr_hit[g] && (!slice_full[g] || pop_ok[g]);

        vc_fifo_slice #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_slice (
            .clk    (clk),
            .arst_n (arst_n),
            .push   (push_ok[g]),
            .pop    (pop_ok[g]),
            .din    (wr_data),
            .dout   (slice_dout[g]),
            .count  (slice_count[g]),
            .empty  (slice_empty[g]),
            .full   (slice_full[g])
        );

        assign vc_count[g*CNT_W +: CNT_W] = slice_count[g];
    end

    assign vc_empty = slice_empty;
    assign vc_full  = slice_full;

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (rd_vc == VC_W'(i)) begin
                rd_data  = slice_dout[i];
                rd_valid = !slice_empty[i];
            end
        end
    end

    always_comb begin
        overflow_evt    = wr_en && (push_ok == '0);
        underflow_evt   = rd_en && (pop_ok == '0);
        err_overflow_d  = err_overflow_q  | overflow_evt;
        err_underflow_d = err_underflow_q | underflow_evt;
        credit_valid_d  = |pop_ok;
        credit_vc_d     = (|pop_ok) ? rd_vc : credit_vc_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            credit_valid_q  <= 1'b0;
            credit_vc_q     <= '0;
        end else begin
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
            credit_valid_q  <= credit_valid_d;
            credit_vc_q     <= credit_vc_d;
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign credit_valid  = credit_valid_q;
    assign credit_vc     = credit_vc_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (arst_n && overflow_evt && !err_overflow_q) begin
            $info("vc_input_buffer@%0d: err_overflow raised, write to vc %0d", ROUTER_POS, wr_vc);
        end
        if (arst_n && underflow_evt && !err_underflow_q) begin
            $info("vc_input_buffer@%0d: err_underflow raised, read from vc %0d", ROUTER_POS, rd_vc);
        end
    end
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: a DEPTH=4 and a DEPTH=3 instance share stimulus and
// are checked every cycle against a queue-based model, plus literal spot checks.
module tb_vc_input_buffer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        wr_en, rd_en;
    logic        wr_vc, rd_vc;
    logic [31:0] wr_data;

    logic [31:0] o_rd_data [2];
    logic        o_rd_valid [2];
    logic [1:0]  o_empty [2];
    logic [1:0]  o_full [2];
    logic        o_cv [2];
    logic        o_cvc [2];
    logic        o_ovf [2];
    logic        o_unf [2];
    logic [5:0]  vc_count0;
    logic [3:0]  vc_count1;
    logic [31:0] o_cnt [2];

    assign o_cnt[0] = {26'b0, vc_count0};
    assign o_cnt[1] = {28'b0, vc_count1};

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    vc_input_buffer #(.NUM_VC(2), .DEPTH(4), .DATA_W(32), .ROUTER_POS(0)) u_dut0 (
        .clk(clk), .arst_n(arst_n),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc),
        .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]),
        .vc_count(vc_count0), .vc_empty(o_empty[0]), .vc_full(o_full[0]),
        .credit_valid(o_cv[0]), .credit_vc(o_cvc[0]),
        .err_overflow(o_ovf[0]), .err_underflow(o_unf[0])
    );

    vc_input_buffer #(.NUM_VC(2), .DEPTH(3), .DATA_W(32), .ROUTER_POS(1)) u_dut1 (
        .clk(clk), .arst_n(arst_n),
        .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc),
        .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]),
        .vc_count(vc_count1), .vc_empty(o_empty[1]), .vc_full(o_full[1]),
        .credit_valid(o_cv[1]), .credit_vc(o_cvc[1]),
        .err_overflow(o_ovf[1]), .err_underflow(o_unf[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    // Reference model: one queue per VC per instance.
    logic [31:0] mq [2][2][$];
    bit m_cv [2];
    bit m_cvc [2];
    bit m_ovf [2];
    bit m_unf [2];

    always @(posedge clk or negedge arst_n) begin
        bit pop_ok;
        bit push_ok;
        if (!arst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int v = 0; v < 2; v++) mq[k][v].delete();
                m_cv[k] = 0; m_cvc[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                pop_ok  = rd_en && (mq[k][rd_vc].size() > 0);
                push_ok = wr_en && ((mq[k][wr_vc].size() < depth_of(k)) || (pop_ok && rd_vc == wr_vc));
                if (wr_en && !push_ok) m_ovf[k] = 1;
                if (rd_en && !pop_ok) m_unf[k] = 1;
                m_cv[k] = pop_ok;
                if (pop_ok) m_cvc[k] = rd_vc;
                if (pop_ok) void'(mq[k][rd_vc].pop_front());
                if (push_ok) mq[k][wr_vc].push_back(wr_data);
            end
        end
    end

    always @(negedge clk) begin
        int cw, sz;
        logic [31:0] ec;
        logic [1:0] ee, ef;
        #1;
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                cw = (k == 0) ? 3 : 2;
                ec = '0; ee = '0; ef = '0;
                for (int v = 0; v < 2; v++) begin
                    sz = mq[k][v].size();
                    ec = ec | (32'(sz) << (v * cw));
                    ee[v] = (sz == 0);
                    ef[v] = (sz == depth_of(k));
                end
                chk("vc_count", k, o_cnt[k], ec);
                chk("vc_empty", k, {30'b0, o_empty[k]}, {30'b0, ee});
                chk("vc_full", k, {30'b0, o_full[k]}, {30'b0, ef});
                chk("rd_valid", k, {31'b0, o_rd_valid[k]}, {31'b0, mq[k][rd_vc].size() > 0});
                if (mq[k][rd_vc].size() > 0) chk("rd_data", k, o_rd_data[k], mq[k][rd_vc][0]);
                chk("credit_valid", k, {31'b0, o_cv[k]}, {31'b0, m_cv[k]});
                if (m_cv[k]) chk("credit_vc", k, {31'b0, o_cvc[k]}, {31'b0, m_cvc[k]});
                chk("err_overflow", k, {31'b0, o_ovf[k]}, {31'b0, m_ovf[k]});
                chk("err_underflow", k, {31'b0, o_unf[k]}, {31'b0, m_unf[k]});
            end
        end
    end

    task automatic step(input bit we, input bit wv, input logic [31:0] wd, input bit re, input bit rv);
        wr_en = we; wr_vc = wv; wr_data = wd; rd_en = re; rd_vc = rv;
        @(negedge clk);
    endtask

    task automatic rd_chk(input bit vc, input logic [31:0] d);
        wr_en = 0; rd_en = 1; rd_vc = vc;
        #1;
        chk("lit_rd_data", 0, o_rd_data[0], d);
        @(negedge clk);
        chk("lit_credit_valid", 0, {31'b0, o_cv[0]}, 32'd1);
        chk("lit_credit_vc", 0, {31'b0, o_cvc[0]}, {31'b0, vc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 0; wr_en = 0; rd_en = 0; wr_vc = 0; rd_vc = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_count", 0, o_cnt[0], 32'd0);
        chk("rst_empty", 0, {30'b0, o_empty[0]}, 32'd3);
        chk("rst_full", 0, {30'b0, o_full[0]}, 32'd0);
        chk("rst_credit", 0, {31'b0, o_cv[0]}, 32'd0);
        chk("rst_err", 0, {30'b0, o_ovf[0], o_unf[0]}, 32'd0);
        arst_n = 1;
        check_en = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("idle_count", 0, o_cnt[0], 32'd0);

        // Full VC0, simultaneous read+write: both accepted, no overflow.
        for (int i = 0; i < 4; i++) step(1, 0, 32'h50 + i, 0, 0);
        step(1, 0, 32'h55, 1, 0);
        chk("full_rw_count", 0, o_cnt[0], 32'd4);
        chk("full_rw_ovf", 0, {31'b0, o_ovf[0]}, 32'd0);
        rd_chk(0, 32'h51); rd_chk(0, 32'h52); rd_chk(0, 32'h53); rd_chk(0, 32'h55);

        // Empty VC0, simultaneous: write accepted, read rejected.
        step(1, 0, 32'h66, 1, 0);
        chk("empty_rw_count", 0, o_cnt[0], 32'd1);
        chk("empty_rw_unf", 0, {31'b0, o_unf[0]}, 32'd1);
        chk("empty_rw_credit", 0, {31'b0, o_cv[0]}, 32'd0);
        rd_chk(0, 32'h66);

        // Overflow on VC1.
        for (int i = 0; i < 5; i++) step(1, 1, 32'hA0 + i, 0, 0);
        chk("ovf_full", 0, {30'b0, o_full[0]}, 32'd2);
        chk("ovf_count", 0, o_cnt[0], 32'h20);
        chk("ovf_flag", 0, {31'b0, o_ovf[0]}, 32'd1);
        for (int i = 0; i < 4; i++) rd_chk(1, 32'hA0 + i);
        chk("ovf_drained", 0, {30'b0, o_empty[0]}, 32'd3);

        // Interleaved VCs.
        step(1, 0, 32'h10, 0, 0);
        step(1, 1, 32'h20, 0, 0);
        step(1, 0, 32'h11, 0, 0);
        chk("il_count", 0, o_cnt[0], 32'h0A);
        rd_chk(0, 32'h10); rd_chk(1, 32'h20); rd_chk(0, 32'h11);

        // Pointer wrap on VC0.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h30 + i, 0, 0);
            rd_chk(0, 32'h30 + i);
        end
        chk("wrap_count", 0, o_cnt[0], 32'd0);

        // Reset mid-burst with a credit in flight.
        step(1, 1, 32'h70, 0, 0);
        step(1, 1, 32'h71, 0, 0);
        wr_en = 0; rd_en = 1; rd_vc = 1;
        @(posedge clk);
        #1;
        chk("mid_credit", 0, {31'b0, o_cv[0]}, 32'd1);
        chk("mid_count", 0, o_cnt[0], 32'h08);
        #1;
        arst_n = 0;
        #1;
        chk("rst_mid_count", 0, o_cnt[0], 32'd0);
        chk("rst_mid_credit", 0, {31'b0, o_cv[0]}, 32'd0);
        @(negedge clk);
        rd_en = 0;
        @(negedge clk);
        arst_n = 1;
        step(0, 0, 0, 0, 0);
        chk("post_rst_credit", 0, {31'b0, o_cv[0]}, 32'd0);
        step(1, 1, 32'h77, 0, 0);
        rd_chk(1, 32'h77);

        // Random traffic: write-heavy, read-heavy, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int wp, rp;
                wp = (ph == 0) ? 85 : (ph == 1) ? 25 : 55;
                rp = (ph == 0) ? 25 : (ph == 1) ? 85 : 55;
                step($urandom_range(0, 99) < wp, 1'($urandom_range(0, 1)), $urandom,
                     $urandom_range(0, 99) < rp, 1'($urandom_range(0, 1)));
            end
        end
        step(0, 0, 0, 0, 0);
        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
